// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : button_debouncer
//  Description : Conditions one raw asynchronous input, such as a pushbutton
//                or switch. The input is synchronised through two flops. A
//                new level is accepted only after STABLE_CYCLES consecutive
//                synchronised samples agree. The block drives a clean level
//                (y), one-cycle rise/fall strobes and a wrapping count of
//                accepted presses.
//  Ports       : clk          - clock; all state changes on the rising edge
//                rst          - synchronous active-high reset
//                a            - raw asynchronous input
//                y            - debounced level (registered)
//                rise         - one-cycle strobe on the first cycle y==1
//                fall         - one-cycle strobe on the first cycle y==0
//                press_count  - accepted rising transitions, wraps
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 3,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a,
    output logic                   y,
    output logic                   rise,
    output logic                   fall,
    output logic [COUNT_WIDTH-1:0] press_count
);

    localparam logic [1:0] c_ST_LOW      = 2'd0;
    localparam logic [1:0] c_ST_CHK_HIGH = 2'd1;
    localparam logic [1:0] c_ST_HIGH     = 2'd2;
    localparam logic [1:0] c_ST_CHK_LOW  = 2'd3;

    // The final qualifying sample arrives while the counter holds this value.
    // The transition into CHK_* has already counted the first sample.
    localparam logic [CNT_WIDTH-1:0] c_CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);

    logic                   r_s1;
    logic                   r_s2;
    logic [1:0]             r_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_y;
    logic                   r_rise;
    logic                   r_fall;
    logic [COUNT_WIDTH-1:0] r_press_count;

    // Two-flop synchroniser. Only r_s2 feeds the state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= a;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_LOW;
            r_cnt         <= '0;
            r_y           <= 1'b0;
            r_rise        <= 1'b0;
            r_fall        <= 1'b0;
            r_press_count <= '0;
        end else begin
            // Strobes are high for a single cycle only.
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                c_ST_LOW: begin
                    if (r_s2) begin
                        r_state <= c_ST_CHK_HIGH;
                        r_cnt   <= c_CNT_ONE;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                c_ST_CHK_HIGH: begin
                    if (!r_s2) begin
                        // The old level reappeared: treat it as a glitch and restart.
                        r_state <= c_ST_LOW;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state       <= c_ST_HIGH;
                        r_cnt         <= '0;
                        r_y           <= 1'b1;
                        r_rise        <= 1'b1;
                        r_press_count <= r_press_count + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_HIGH: begin
                    if (!r_s2) begin
                        r_state <= c_ST_CHK_LOW;
                        r_cnt   <= c_CNT_ONE;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                c_ST_CHK_LOW: begin
                    if (r_s2) begin
                        r_state <= c_ST_HIGH;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_ST_LOW;
                        r_cnt   <= '0;
                        r_y     <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_LOW;
                    r_cnt   <= '0;
                    r_y     <= 1'b0;
                end
            endcase
        end
    end

    assign y           = r_y;
    assign rise        = r_rise;
    assign fall        = r_fall;
    assign press_count = r_press_count;

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_debouncer
//  Description : Self-checking bench for button_debouncer. A run-length
//                reference model predicts y, rise, fall and press_count on
//                every clock edge. Directed scenarios and random bounce
//                segments drive the input.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       a;
    logic       y;
    logic       rise;
    logic       fall;
    logic [7:0] press_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state. m_pipe holds the last two input samples, where
    // m_pipe[1] is the older one. m_run counts consecutive visible samples
    // that differ from the current level.
    int m_pipe [2];
    int m_run;
    int m_y;
    int m_rise;
    int m_fall;
    int m_cnt;

    button_debouncer #(
        .STABLE_CYCLES (STABLE),
        .CNT_WIDTH     (3),
        .COUNT_WIDTH   (8)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .y           (y),
        .rise        (rise),
        .fall        (fall),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one clock edge with the given rst and a values. Advance the model,
    // then compare the DUT against it 1 ns after the edge.
    task automatic step(input bit r, input bit av);
        int vis;
        rst = r;
        a   = av;
        @(posedge clk);
        #1;
        if (r) begin
            m_pipe[0] = 0; m_pipe[1] = 0;
            m_run = 0; m_y = 0; m_rise = 0; m_fall = 0; m_cnt = 0;
        end else begin
            vis       = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = int'(av);
            m_rise = 0;
            m_fall = 0;
            if (vis != m_y) begin
                m_run++;
                if (m_run == STABLE) begin
                    m_y   = vis;
                    m_run = 0;
                    if (vis == 1) begin
                        m_rise = 1;
                        m_cnt  = (m_cnt + 1) % 256;
                    end else begin
                        m_fall = 1;
                    end
                end
            end else begin
                m_run = 0;
            end
        end
        check_value("y", int'(y), m_y);
        check_value("rise", int'(rise), m_rise);
        check_value("fall", int'(fall), m_fall);
        check_value("press_count", int'(press_count), m_cnt);
        check_value("rise_and_fall", int'(rise & fall), 0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
    endtask

    initial begin
        int first_edge;
        int n_rise;
        int lvl;
        int len;

        rst = 1'b1;
        a   = 1'b0;
        m_pipe[0] = 0; m_pipe[1] = 0;
        m_run = 0; m_y = 0; m_rise = 0; m_fall = 0; m_cnt = 0;

        // 1: reset with a=1, then release and hold a=1.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check_value("t1_reset_y", int'(y), 0);
        check_value("t1_reset_count", int'(press_count), 0);
        first_edge = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b1);
            if (rise && first_edge == 0) first_edge = i;
        end
        check_value("t1_rise_edge", first_edge, 6);
        check_value("t1_count", int'(press_count), 1);

        // 2: a short pulse of 3 clocks is rejected.
        do_reset();
        n_rise = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            n_rise += int'(rise);
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0);
            n_rise += int'(rise);
        end
        check_value("t2_rises", n_rise, 0);
        check_value("t2_y", int'(y), 0);
        check_value("t2_count", int'(press_count), 0);

        // 3: a clean high period followed by a clean low period.
        do_reset();
        first_edge = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b1);
            if (rise && first_edge == 0) first_edge = i;
        end
        check_value("t3_rise_edge", first_edge, 6);
        check_value("t3_y_high", int'(y), 1);
        first_edge = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b0);
            if (fall && first_edge == 0) first_edge = i;
        end
        check_value("t3_fall_edge", first_edge, 6);
        check_value("t3_count", int'(press_count), 1);

        // 4: bounce 1,0,1,1,0,1 then hold 1. The stable 1 begins at edge 6,
        //    so rise is expected on edge 11.
        do_reset();
        begin
            bit [5:0] bounce;
            bounce = 6'b101101;
            first_edge = 0;
            n_rise = 0;
            for (int i = 1; i <= 18; i++) begin
                step(1'b0, (i <= 6) ? bounce[6-i] : 1'b1);
                n_rise += int'(rise);
                if (rise && first_edge == 0) first_edge = i;
            end
        end
        check_value("t4_rise_edge", first_edge, 11);
        check_value("t4_rises", n_rise, 1);
        check_value("t4_count", int'(press_count), 1);

        // 5: 256 clean presses, so press_count wraps.
        do_reset();
        for (int p = 1; p <= 256; p++) begin
            for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
            for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
            if (p == 255) check_value("t5_count_255", int'(press_count), 255);
            if (p == 256) check_value("t5_count_wrap", int'(press_count), 0);
        end

        // 6: reset during qualification (CHK_HIGH, cnt==2), with a held at 1.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check_value("t6_y", int'(y), 0);
        check_value("t6_rise", int'(rise), 0);
        check_value("t6_count", int'(press_count), 0);
        first_edge = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b1);
            if (rise && first_edge == 0) first_edge = i;
        end
        check_value("t6_rise_edge", first_edge, 6);

        // Random segments that mix glitches with stable levels.
        do_reset();
        for (int s = 0; s < 400; s++) begin
            lvl = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 9));
            for (int i = 0; i < len; i++) step(1'b0, lvl[0]);
            if ($urandom_range(0, 49) == 0) step(1'b1, lvl[0]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
